// File: rtl/package_settings.sv
// Project-wide datapath settings shared by the CORDIC blocks.
package package_settings;
    localparam int FULL_SIZE = 16;
endpackage

// File: rtl/cordic_kernel_scheduler_if.sv
// Request, kernel and result bundle of the CORDIC kernel scheduler.
interface cordic_kernel_scheduler_if #(
    parameter int NUM_CH       = 4,
    parameter int FULL_SIZE    = package_settings::FULL_SIZE,
    parameter int MAX_INFLIGHT = 16
);
    localparam int IW = $clog2(MAX_INFLIGHT) + 1;

    logic                        sched_enable;
    logic [NUM_CH-1:0]           req_valid;
    logic [NUM_CH-1:0]           req_ready;
    logic [NUM_CH*FULL_SIZE-1:0] req_data_i;
    logic [NUM_CH*FULL_SIZE-1:0] req_data_q;
    logic [FULL_SIZE-1:0]        kern_data_i;
    logic [FULL_SIZE-1:0]        kern_data_q;
    logic                        kern_enable;
    logic [FULL_SIZE-1:0]        kern_out_i;
    logic [FULL_SIZE-1:0]        kern_out_q;
    logic [FULL_SIZE-1:0]        kern_out_theta;
    logic                        kern_out_valid;
    logic [NUM_CH-1:0]           res_valid;
    logic [FULL_SIZE-1:0]        res_i;
    logic [FULL_SIZE-1:0]        res_q;
    logic [FULL_SIZE-1:0]        res_theta;
    logic [IW-1:0]               inflight;
    logic                        err_orphan;

    modport master (
        input  sched_enable, req_valid, req_data_i, req_data_q,
        input  kern_out_i, kern_out_q, kern_out_theta, kern_out_valid,
        output req_ready, kern_data_i, kern_data_q, kern_enable,
        output res_valid, res_i, res_q, res_theta, inflight, err_orphan
    );

    modport slave (
        output sched_enable, req_valid, req_data_i, req_data_q,
        output kern_out_i, kern_out_q, kern_out_theta, kern_out_valid,
        input  req_ready, kern_data_i, kern_data_q, kern_enable,
        input  res_valid, res_i, res_q, res_theta, inflight, err_orphan
    );
endinterface

// File: rtl/cordic_kernel_scheduler.sv
// Round-robin issue of channel operands into a shared CORDIC kernel,
// with in-order tag tracking to route kernel results back to channels.
module cordic_kernel_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int FULL_SIZE    = package_settings::FULL_SIZE,
    parameter int MAX_INFLIGHT = 16
) (
    input logic                       clk,
    input logic                       reset_n,
    cordic_kernel_scheduler_if.master bus
);
    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int IW = PW + 1;
    localparam logic [IW-1:0] FULL_CNT = IW'(MAX_INFLIGHT);

    logic                 rst_q;
    logic [CW-1:0]        ptr;
    logic [CW-1:0]        sel;
    logic [CW-1:0]        cand;
    logic                 hit;
    logic                 can_issue;
    logic                 xfer;
    logic                 pop;
    logic [CW-1:0]        head;
    logic [CW-1:0]        tags [MAX_INFLIGHT];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [IW-1:0]        cnt;
    logic                 kern_en;
    logic [FULL_SIZE-1:0] kdi;
    logic [FULL_SIZE-1:0] kdq;
    logic [NUM_CH-1:0]    rv;
    logic [FULL_SIZE-1:0] ri;
    logic [FULL_SIZE-1:0] rq;
    logic [FULL_SIZE-1:0] rt;
    logic                 orphan;

    // Grants stay off for the first edge after reset release.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) rst_q <= 1'b1;
        else         rst_q <= 1'b0;
    end

    always_comb begin
        sel  = ptr;
        hit  = 1'b0;
        cand = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (cand == CW'(NUM_CH - 1)) ? '0 : cand + CW'(1);
            if (!hit && bus.req_valid[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
    end

    assign can_issue = !rst_q && bus.sched_enable && (cnt != FULL_CNT);
    assign xfer      = can_issue && hit;
    assign pop       = bus.kern_out_valid && (cnt != '0);
    assign head      = tags[rd_ptr];

    assign bus.req_ready   = xfer ? (NUM_CH'(1) << sel) : '0;
    assign bus.kern_enable = kern_en;
    assign bus.kern_data_i = kdi;
    assign bus.kern_data_q = kdq;
    assign bus.res_valid   = rv;
    assign bus.res_i       = ri;
    assign bus.res_q       = rq;
    assign bus.res_theta   = rt;
    assign bus.inflight    = cnt;
    assign bus.err_orphan  = orphan;

    always_ff @(posedge clk) begin
        if (xfer) tags[wr_ptr] <= sel;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            ptr     <= CW'(NUM_CH - 1);
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            kern_en <= 1'b0;
            kdi     <= '0;
            kdq     <= '0;
            rv      <= '0;
            ri      <= '0;
            rq      <= '0;
            rt      <= '0;
            orphan  <= 1'b0;
        end else begin
            kern_en <= xfer;
            if (xfer) begin
                ptr    <= sel;
                kdi    <= bus.req_data_i[sel*FULL_SIZE +: FULL_SIZE];
                kdq    <= bus.req_data_q[sel*FULL_SIZE +: FULL_SIZE];
                wr_ptr <= wr_ptr + PW'(1);
            end
            rv <= pop ? (NUM_CH'(1) << head) : '0;
            if (pop) begin
                ri     <= bus.kern_out_i;
                rq     <= bus.kern_out_q;
                rt     <= bus.kern_out_theta;
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({xfer, pop})
                2'b10:   cnt <= cnt + IW'(1);
                2'b01:   cnt <= cnt - IW'(1);
                default: cnt <= cnt;
            endcase
            // A result with no tag outstanding cannot be routed.
            if (bus.kern_out_valid && cnt == '0) orphan <= 1'b1;
        end
    end
endmodule

// File: doc/cordic_kernel_scheduler.md
CORDIC_KERNEL_SCHEDULER -- requirements
Module: cordic_kernel_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of requesting channels, 2..8.
REQ-002 Parameter FULL_SIZE, default package_settings FULL_SIZE: sample and angle width, signed.
REQ-003 Parameter MAX_INFLIGHT, default 16: maximum operations in the kernel at once, power of two, 2..64.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-high reset; asserted = 1.
REQ-006 Port sched_enable, input, 1: 1 = issue allowed; 0 = no new grants, in-flight results still returned.
REQ-007 Port req_valid, input, NUM_CH: per-channel request present.
REQ-008 Port req_ready, output, NUM_CH: per-channel grant; at most one bit high per cycle.
REQ-009 Port req_data_i, input, NUM_CH*FULL_SIZE: per-channel I operand; channel k occupies bits [k*FULL_SIZE +: FULL_SIZE].
REQ-010 Port req_data_q, input, NUM_CH*FULL_SIZE: per-channel Q operand; same packing as req_data_i.
REQ-011 Port kern_data_i, output, FULL_SIZE: I operand to the kernel.
REQ-012 Port kern_data_q, output, FULL_SIZE: Q operand to the kernel.
REQ-013 Port kern_enable, output, 1: kernel input strobe.
REQ-014 Port kern_out_i, input, FULL_SIZE: kernel I result.
REQ-015 Port kern_out_q, input, FULL_SIZE: kernel Q result.
REQ-016 Port kern_out_theta, input, FULL_SIZE: kernel angle result.
REQ-017 Port kern_out_valid, input, 1: kernel result strobe.
REQ-018 Port res_valid, output, NUM_CH: one-hot strobe naming the destination channel.
REQ-019 Port res_i, output, FULL_SIZE: shared result bus, I.
REQ-020 Port res_q, output, FULL_SIZE: shared result bus, Q.
REQ-021 Port res_theta, output, FULL_SIZE: shared result bus, angle.
REQ-022 Port inflight, output, $clog2(MAX_INFLIGHT)+1: operations issued but not yet returned.
REQ-023 Port err_orphan, output, 1: sticky error flag.

Function
REQ-024 A transfer on channel k occurs only when req_valid[k] and req_ready[k] are both 1 in the same cycle.
REQ-025 req_ready is combinational from req_valid, the RR pointer, sched_enable and inflight; it is all-zero when sched_enable=0 or inflight==MAX_INFLIGHT.
REQ-026 Arbitration is round-robin: the grant goes to the first valid channel at or after index ptr+1 (mod NUM_CH); after a transfer, ptr takes the granted index.
REQ-027 Issue latency: a transfer in cycle N drives kern_enable=1 with the registered operands in cycle N+1; otherwise kern_enable=0 and the operands hold their last values.
REQ-028 Each transfer pushes the granted channel index into a tag FIFO of depth MAX_INFLIGHT.
REQ-029 On kern_out_valid=1 with the tag FIFO non-empty: the head tag is popped; in the next cycle res_valid[tag]=1 and res_i/q/theta equal the registered kern_out values.
REQ-030 No backpressure on results: res_valid is a one-cycle strobe; the kernel is never stalled.
REQ-031 On kern_out_valid=1 with the tag FIFO empty: no pop, res_valid stays 0, and err_orphan is set and stays 1 until reset.
REQ-032 inflight increments on a transfer and decrements on a valid pop; a transfer and a pop in the same cycle leave it unchanged; it never exceeds MAX_INFLIGHT or wraps below 0.
REQ-033 Results return in issue order; tag FIFO pointers wrap modulo MAX_INFLIGHT.
REQ-034 While inflight==MAX_INFLIGHT, a pop in cycle N re-enables grants in cycle N+1 (registered inflight).
REQ-035 Deasserting sched_enable blocks grants from the same cycle; pending returns drain normally.

Reset
REQ-036 While reset_n=1, all of these are held at 0: req_ready, kern_enable, kern_data_i/q, res_valid, res_i/q/theta, inflight, err_orphan.
REQ-037 While reset_n=1, the RR pointer is NUM_CH-1 (channel 0 wins first) and the tag FIFO is empty.
REQ-038 Reset mid-operation discards all in-flight tags; results returned later are treated as orphans per REQ-031.
REQ-039 Release of reset is synchronized internally; the first grant is possible in the second clk edge after deassertion.

Verification
REQ-040 All 4 channels valid continuously, kernel latency 8, sched_enable=1 -> grants in order 0,1,2,3,0,... one per cycle; each res_valid matches its issue tag; inflight settles at 8.
REQ-041 MAX_INFLIGHT=4, kernel stalled from returning -> after 4 grants req_ready=0000 and inflight=4; one kern_out_valid -> a single grant follows one cycle later.
REQ-042 Same-cycle transfer and kern_out_valid at inflight=3 -> inflight stays 3; FIFO order preserved.
REQ-043 kern_out_valid pulse with inflight=0 -> err_orphan=1, res_valid=0, err_orphan persists until reset.
REQ-044 reset_n pulsed with inflight=5 -> all outputs 0 at once; the next grant goes to channel 0.
REQ-045 sched_enable=0 with 3 in flight -> no grants; 3 results delivered; inflight reaches 0.
